game_sequencer: RTL and testbench



---
 rtl/game_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_game_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Turn sequencer for the two 11x11 stone planes: clears both boards on start,
// validates move requests, writes the stone, then samples win to pick next turn/win/draw.
module game_sequencer #(
  parameter int SIZE     = 11,
  parameter int WIN_WAIT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mv_valid,
  input  logic                   mv_player,
  input  logic [3:0]             mv_x,
  input  logic [3:0]             mv_y,
  output logic                   mv_ready,
  output logic                   mv_err,
  output logic [1:0]             err_code,
  output logic [1:0]             brd_write,
  output logic [3:0]             brd_x,
  output logic [3:0]             brd_y,
  output logic                   brd_d,
  input  logic [SIZE*SIZE-1:0]   board0,
  input  logic [SIZE*SIZE-1:0]   board1,
  input  logic [1:0]             win,
  output logic                   turn,
  output logic [6:0]             move_cnt,
  output logic                   busy,
  output logic                   game_over,
  output logic                   winner,
  output logic                   draw
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_TURN  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int         CELLS = SIZE * SIZE;
  localparam int         IW    = $clog2(CELLS);
  localparam int         WW    = $clog2(WIN_WAIT + 1);
  localparam logic [3:0] LAST  = 4'(SIZE - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    cx_q, cx_d, cy_q, cy_d;
  logic [3:0]    mx_q, mx_d, my_q, my_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          turn_q, turn_d;
  logic [6:0]    move_cnt_q, move_cnt_d;
  logic          game_over_q, game_over_d, winner_q, winner_d, draw_q, draw_d;
  logic          mv_err_q, mv_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [1:0]    brd_write_q, brd_write_d;
  logic [3:0]    brd_x_q, brd_x_d, brd_y_q, brd_y_d;
  logic          brd_d_q, brd_d_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] idx;
  logic          occupied;

  assign idx      = IW'(mv_x) * IW'(SIZE) + IW'(mv_y);
  assign occupied = board0[idx] | board1[idx];
  assign mv_ready = (state_q == S_TURN) && !start;

  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    mx_d        = mx_q;
    my_d        = my_q;
    wcnt_d      = wcnt_q;
    turn_d      = turn_q;
    move_cnt_d  = move_cnt_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    draw_d      = draw_q;
    mv_err_d    = 1'b0;
    err_code_d  = 2'b00;

    if (start) begin
      state_d     = S_CLEAR;
      cx_d        = 4'd0;
      cy_d        = 4'd0;
      turn_d      = 1'b0;
      move_cnt_d  = 7'd0;
      game_over_d = 1'b0;
      winner_d    = 1'b0;
      draw_d      = 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (cy_q == LAST) begin
            cy_d = 4'd0;
            if (cx_q == LAST) state_d = S_TURN;
            else              cx_d    = cx_q + 4'd1;
          end else begin
            cy_d = cy_q + 4'd1;
          end
        end
        S_TURN: begin
          // Range is checked first so an out-of-range index never reaches the occupancy test.
          if (mv_valid) begin
            if (mv_x > LAST || mv_y > LAST) begin
              mv_err_d   = 1'b1;
              err_code_d = 2'b01;
            end else if (mv_player != turn_q) begin
              mv_err_d   = 1'b1;
              err_code_d = 2'b10;
            end else if (occupied) begin
              mv_err_d   = 1'b1;
              err_code_d = 2'b11;
            end else begin
              mx_d    = mv_x;
              my_d    = mv_y;
              state_d = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          wcnt_d  = WW'(WIN_WAIT);
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (wcnt_q == WW'(1)) begin
            move_cnt_d = move_cnt_q + 7'd1;
            if (win[turn_q]) begin
              state_d     = S_DONE;
              game_over_d = 1'b1;
              winner_d    = turn_q;
            end else if (move_cnt_q + 7'd1 == 7'(CELLS)) begin
              state_d     = S_DONE;
              game_over_d = 1'b1;
              draw_d      = 1'b1;
            end else begin
              turn_d  = ~turn_q;
              state_d = S_TURN;
            end
          end else begin
            wcnt_d = wcnt_q - WW'(1);
          end
        end
        default: ;
      endcase
    end

    // Board-port registers follow the next state so each beat lines up with its state cycle.
    brd_write_d = 2'b00;
    brd_x_d     = 4'd0;
    brd_y_d     = 4'd0;
    brd_d_d     = 1'b0;
    if (state_d == S_CLEAR) begin
      brd_write_d = 2'b11;
      brd_x_d     = cx_d;
      brd_y_d     = cy_d;
    end else if (state_d == S_WRITE) begin
      brd_write_d = turn_d ? 2'b10 : 2'b01;
      brd_x_d     = mx_d;
      brd_y_d     = my_d;
      brd_d_d     = 1'b1;
    end
    busy_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cx_q        <= 4'd0;
      cy_q        <= 4'd0;
      mx_q        <= 4'd0;
      my_q        <= 4'd0;
      wcnt_q      <= '0;
      turn_q      <= 1'b0;
      move_cnt_q  <= 7'd0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      draw_q      <= 1'b0;
      mv_err_q    <= 1'b0;
      err_code_q  <= 2'b00;
      brd_write_q <= 2'b00;
      brd_x_q     <= 4'd0;
      brd_y_q     <= 4'd0;
      brd_d_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      wcnt_q      <= wcnt_d;
      turn_q      <= turn_d;
      move_cnt_q  <= move_cnt_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      draw_q      <= draw_d;
      mv_err_q    <= mv_err_d;
      err_code_q  <= err_code_d;
      brd_write_q <= brd_write_d;
      brd_x_q     <= brd_x_d;
      brd_y_q     <= brd_y_d;
      brd_d_q     <= brd_d_d;
      busy_q      <= busy_d;
    end
  end

  assign mv_err    = mv_err_q;
  assign err_code  = err_code_q;
  assign brd_write = brd_write_q;
  assign brd_x     = brd_x_q;
  assign brd_y     = brd_y_q;
  assign brd_d     = brd_d_q;
  assign turn      = turn_q;
  assign move_cnt  = move_cnt_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign draw      = draw_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: two-plane board model with a five-in-column win
// on x=0 (y=0..4), checked against hand-computed expectations.
module tb_game_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         mv_valid = 1'b0;
  logic         mv_player = 1'b0;
  logic [3:0]   mv_x = 4'd0;
  logic [3:0]   mv_y = 4'd0;
  logic         mv_ready, mv_err;
  logic [1:0]   err_code, brd_write;
  logic [3:0]   brd_x, brd_y;
  logic         brd_d;
  logic [120:0] b0 = '0;
  logic [120:0] b1 = '0;
  logic [1:0]   win;
  logic         win_en = 1'b1;
  logic         turn;
  logic [6:0]   move_cnt;
  logic         busy, game_over, winner, draw;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_sequencer #(.SIZE(11), .WIN_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mv_valid(mv_valid), .mv_player(mv_player), .mv_x(mv_x), .mv_y(mv_y),
    .mv_ready(mv_ready), .mv_err(mv_err), .err_code(err_code),
    .brd_write(brd_write), .brd_x(brd_x), .brd_y(brd_y), .brd_d(brd_d),
    .board0(b0), .board1(b1), .win(win),
    .turn(turn), .move_cnt(move_cnt), .busy(busy),
    .game_over(game_over), .winner(winner), .draw(draw)
  );

  // Board model: single-plane stores, win when column x=0 holds y=0..4.
  always @(posedge clk) begin
    if (brd_write[0]) b0[int'(brd_x) * 11 + int'(brd_y)] <= brd_d;
    if (brd_write[1]) b1[int'(brd_x) * 11 + int'(brd_y)] <= brd_d;
  end
  assign win = win_en ? {&b1[4:0], &b0[4:0]} : 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered during cycle k+1 after start was sampled at edge k.
  task automatic sweep;
    int bad = 0;
    for (int i = 0; i < 121; i++) begin
      if (busy !== 1'b1 || brd_write !== 2'b11 || brd_d !== 1'b0 || mv_ready !== 1'b0 ||
          brd_x !== 4'(i / 11) || brd_y !== 4'(i % 11)) bad++;
      tick;
    end
    check("clear_sweep_beats", bad, 0);
    check("ready_after_clear", mv_ready, 1);
    check("busy_after_clear", busy, 0);
    check("wr_after_clear", brd_write, 0);
  endtask

  task automatic start_game;
    start = 1'b1;
    tick;
    start = 1'b0;
    sweep;
  endtask

  task automatic move(input bit p, input logic [3:0] x, input logic [3:0] y,
                      input logic [1:0] exp_code, input bit exp_done);
    int t = 0;
    while (mv_ready !== 1'b1 && t < 20) begin
      tick;
      t++;
    end
    if (mv_ready !== 1'b1) begin
      check("ready_timeout", 0, 1);
      return;
    end
    mv_valid = 1'b1; mv_player = p; mv_x = x; mv_y = y;
    tick;
    mv_valid = 1'b0;
    $display("move p%0d (%0d,%0d) mv_err=%0b err_code=%0b", p, x, y, mv_err, err_code);
    check("mv_err", mv_err, exp_code != 2'b00);
    check("err_code", err_code, exp_code);
    if (exp_code != 2'b00) begin
      check("ready_in_err", mv_ready, 1);
      tick;
      check("err_one_cycle", {mv_err, err_code}, 0);
    end else begin
      check("wr_en", brd_write, p ? 2 : 1);
      check("wr_xyd", {brd_x, brd_y, brd_d}, {x, y, 1'b1});
      tick;
      check("wr_off", brd_write, 0);
      tick;
      check("ready_latency", mv_ready, !exp_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #20;
    check("rst_outputs", {mv_ready, mv_err, err_code, brd_write, brd_x, brd_y, brd_d,
                          turn, move_cnt, busy, game_over, winner, draw}, 0);
    #4 rst_n = 1'b1;
    mv_valid = 1'b1;
    repeat (3) tick;
    check("idle_no_ready", {mv_ready, busy, brd_write}, 0);
    mv_valid = 1'b0;

    // Win on the fifth P0 stone in column 0.
    start_game;
    for (int k = 0; k < 4; k++) begin
      check("turn_p0", turn, 0);
      move(1'b0, 4'd0, 4'(k), 2'b00, 1'b0);
      check("turn_p1", turn, 1);
      move(1'b1, 4'd5, 4'(5 + k), 2'b00, 1'b0);
    end
    move(1'b0, 4'd0, 4'd4, 2'b00, 1'b1);
    check("win_result", {game_over, winner, draw}, 3'b100);
    check("win_cnt", move_cnt, 9);
    check("win_ready", mv_ready, 0);
    repeat (3) tick;
    check("done_held", {game_over, mv_ready}, 2'b10);

    // Illegal requests leave turn and count alone.
    start_game;
    check("restart_result", {game_over, winner, draw, move_cnt}, 0);
    move(1'b1, 4'd0, 4'd0, 2'b10, 1'b0);
    check("wrong_turn_state", {turn, move_cnt}, 0);
    move(1'b0, 4'd11, 4'd3, 2'b01, 1'b0);
    check("range_state", {turn, move_cnt}, 0);
    move(1'b0, 4'd2, 4'd2, 2'b00, 1'b0);
    move(1'b1, 4'd3, 4'd3, 2'b00, 1'b0);
    move(1'b0, 4'd2, 4'd2, 2'b11, 1'b0);
    check("occupied_state", {turn, move_cnt}, 2);
    move(1'b0, 4'd3, 4'd3, 2'b11, 1'b0);
    move(1'b0, 4'd4, 4'd15, 2'b01, 1'b0);

    // start during WRITE aborts the move; start with mv_valid drops the move.
    start_game;
    move(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
    mv_valid = 1'b1; mv_player = 1'b1; mv_x = 4'd5; mv_y = 4'd5;
    tick;
    mv_valid = 1'b0;
    check("abort_in_write", brd_write, 2'b10);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("abort_state", {game_over, turn, move_cnt}, 0);
    sweep;
    mv_valid = 1'b1; mv_player = 1'b0; mv_x = 4'd1; mv_y = 4'd1;
    start = 1'b1;
    #1 check("start_blocks_ready", mv_ready, 0);
    tick;
    start = 1'b0;
    mv_valid = 1'b0;
    check("start_drops_move", {mv_err, brd_write, move_cnt}, {1'b0, 2'b11, 7'd0});
    sweep;

    // Asynchronous reset mid-CLEAR at cell (4,7).
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (51) tick;
    check("pre_rst_cell", {busy, brd_x, brd_y}, {1'b1, 4'd4, 4'd7});
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {mv_ready, mv_err, err_code, brd_write, brd_x, brd_y, brd_d,
                                turn, move_cnt, busy, game_over, winner, draw}, 0);
    #2 rst_n = 1'b1;
    repeat (5) tick;
    check("idle_after_rst", {busy, mv_ready, brd_write}, 0);

    // Fill every cell with win held low.
    win_en = 1'b0;
    start_game;
    for (int i = 0; i < 121; i++)
      move(bit'(i % 2), 4'(i / 11), 4'(i % 11), 2'b00, i == 120);
    check("draw_result", {game_over, winner, draw}, 3'b101);
    check("draw_cnt", move_cnt, 121);
    check("draw_ready", mv_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
